// File: rtl/arc4_pkg.sv
// -----------------------------------------------------------------------------
// arc4_pkg
// Shared types and constants for the ARC4 controller slice.
//   state_t   : sequencer states of arc4_ctrl
//   phase_t   : which engine currently owns the S memory
//   phase_of  : maps a sequencer state to the phase that owns the memory in it
// -----------------------------------------------------------------------------
package arc4_pkg;

    localparam int S_DEPTH = 256;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_INIT,
        ST_WAIT_INIT,
        ST_START_KSA,
        ST_WAIT_KSA,
        ST_START_PRGA,
        ST_WAIT_PRGA,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_INIT,
        PH_KSA,
        PH_PRGA
    } phase_t;

    function automatic phase_t phase_of(input state_t s);
        phase_t p;
        case (s)
            ST_START_INIT, ST_WAIT_INIT: p = PH_INIT;
            ST_START_KSA,  ST_WAIT_KSA:  p = PH_KSA;
            ST_START_PRGA, ST_WAIT_PRGA: p = PH_PRGA;
            default:                     p = PH_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/arc4_ctrl_s_mem_mux.sv
// -----------------------------------------------------------------------------
// s_mem_mux
// Combinational steering of the single-port S-memory write/address port to the
// engine that owns the current phase, plus detection of writes attempted by
// any engine that does not own the memory.
// Ports:
//   phase                     : current owner (registered in the controller)
//   <x>_addr/_wrdata/_wren    : per-engine memory request (x = init/ksa/prga)
//   mem_addr/mem_wrdata/mem_wren : S-memory port; all zero when nobody owns it
//   illegal_wr                : a non-owner engine is asserting wren this cycle
// -----------------------------------------------------------------------------
module s_mem_mux
    import arc4_pkg::*;
#(
    parameter int ADDR_W = arc4_pkg::ADDR_W,
    parameter int DATA_W = arc4_pkg::DATA_W
) (
    input  phase_t            phase,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic              mem_wren,
    output logic              illegal_wr
);

    always_comb begin
        mem_addr   = '0;
        mem_wrdata = '0;
        mem_wren   = 1'b0;
        illegal_wr = 1'b0;
        case (phase)
            PH_INIT: begin
                mem_addr   = init_addr;
                mem_wrdata = init_wrdata;
                mem_wren   = init_wren;
                illegal_wr = ksa_wren | prga_wren;
            end
            PH_KSA: begin
                mem_addr   = ksa_addr;
                mem_wrdata = ksa_wrdata;
                mem_wren   = ksa_wren;
                illegal_wr = init_wren | prga_wren;
            end
            PH_PRGA: begin
                mem_addr   = prga_addr;
                mem_wrdata = prga_wrdata;
                mem_wren   = prga_wren;
                illegal_wr = init_wren | ksa_wren;
            end
            default: begin
                // Nobody owns the memory: every write request is a violation.
                illegal_wr = init_wren | ksa_wren | prga_wren;
            end
        endcase
    end

endmodule

// File: rtl/arc4_ctrl.sv
// -----------------------------------------------------------------------------
// arc4_ctrl
// Top-level ARC4 sequencer. On a start request it runs the init, ksa and
// (optionally) prga engines in order using their ready/enable handshake, and
// steers the shared S-memory write/address port to the engine of the phase.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   en / rdy          : start request (honoured only while rdy=1) / idle flag
//   phase             : 0=none, 1=init, 2=ksa, 3=prga (registered)
//   err               : sticky, set when a non-owner engine asserts wren
//   <x>_en / <x>_rdy  : one-cycle start pulse to / ready from each engine
//   <x>_addr/_wrdata/_wren : engine memory requests
//   mem_addr/mem_wrdata/mem_wren : S-memory write/address port
// -----------------------------------------------------------------------------
module arc4_ctrl
    import arc4_pkg::*;
#(
    parameter int ADDR_W   = arc4_pkg::ADDR_W,
    parameter int DATA_W   = arc4_pkg::DATA_W,
    parameter bit RUN_PRGA = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [1:0]        phase,
    output logic              err,
    output logic              init_en,
    output logic              ksa_en,
    output logic              prga_en,
    input  logic              init_rdy,
    input  logic              ksa_rdy,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              init_wren,
    input  logic              ksa_wren,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic              mem_wren
);

    state_t state_reg, state_next;
    phase_t phase_reg;
    logic   err_reg;
    logic   illegal_wr;

    // Phase is registered from the next state so it changes on the same edge
    // as the state and the memory mux never sees a stale owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            phase_reg <= PH_NONE;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_of(state_next);
            if (illegal_wr) begin
                err_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        init_en    = 1'b0;
        ksa_en     = 1'b0;
        prga_en    = 1'b0;
        case (state_reg)
            ST_IDLE:       if (en) state_next = ST_START_INIT;
            ST_START_INIT: begin
                // Start pulse is qualified by ready so it lasts exactly one cycle.
                init_en = init_rdy;
                if (init_rdy) state_next = ST_WAIT_INIT;
            end
            ST_WAIT_INIT:  if (init_rdy) state_next = ST_START_KSA;
            ST_START_KSA: begin
                ksa_en = ksa_rdy;
                if (ksa_rdy) state_next = ST_WAIT_KSA;
            end
            ST_WAIT_KSA:   if (ksa_rdy) state_next = RUN_PRGA ? ST_START_PRGA : ST_DONE;
            ST_START_PRGA: begin
                prga_en = prga_rdy;
                if (prga_rdy) state_next = ST_WAIT_PRGA;
            end
            ST_WAIT_PRGA:  if (prga_rdy) state_next = ST_DONE;
            default:       state_next = ST_IDLE;
        endcase
    end

    assign rdy   = (state_reg == ST_IDLE);
    assign phase = phase_reg;
    assign err   = err_reg;

    s_mem_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .phase      (phase_reg),
        .init_addr  (init_addr),
        .init_wrdata(init_wrdata),
        .init_wren  (init_wren),
        .ksa_addr   (ksa_addr),
        .ksa_wrdata (ksa_wrdata),
        .ksa_wren   (ksa_wren),
        .prga_addr  (prga_addr),
        .prga_wrdata(prga_wrdata),
        .prga_wren  (prga_wren),
        .mem_addr   (mem_addr),
        .mem_wrdata (mem_wrdata),
        .mem_wren   (mem_wren),
        .illegal_wr (illegal_wr)
    );

endmodule

// File: tb/tb_arc4_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arc4_ctrl
// Directed bench for arc4_ctrl. Two instances: dut (RUN_PRGA=1) and dut_b
// (RUN_PRGA=0). Each engine is modelled as ready=1 at rest, dropping ready for
// a fixed busy time (init 256, ksa 512, prga 20 cycles) after its start pulse.
// -----------------------------------------------------------------------------
module tb_arc4_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic en_b = 1'b0;
    logic hold_ksa = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic       rdy, err, init_en, ksa_en, prga_en, mem_wren;
    logic [1:0] phase;
    logic       init_rdy, ksa_rdy, prga_rdy;
    logic [7:0] mem_addr, mem_wrdata;

    logic       rdy_b, err_b, init_en_b, ksa_en_b, prga_en_b, mem_wren_b;
    logic [1:0] phase_b;
    logic       init_rdy_b, ksa_rdy_b, prga_rdy_b;
    logic [7:0] mem_addr_b, mem_wrdata_b;

    logic [7:0] init_addr = 8'h11, ksa_addr = 8'h12, prga_addr = 8'h13;
    logic [7:0] init_wrdata = 8'h21, ksa_wrdata = 8'h22, prga_wrdata = 8'h23;
    logic       init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;

    arc4_ctrl #(.ADDR_W(8), .DATA_W(8), .RUN_PRGA(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .phase(phase), .err(err),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
        .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren)
    );

    arc4_ctrl #(.ADDR_W(8), .DATA_W(8), .RUN_PRGA(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .rdy(rdy_b), .phase(phase_b), .err(err_b),
        .init_en(init_en_b), .ksa_en(ksa_en_b), .prga_en(prga_en_b),
        .init_rdy(init_rdy_b), .ksa_rdy(ksa_rdy_b), .prga_rdy(prga_rdy_b),
        .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
        .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .mem_addr(mem_addr_b), .mem_wrdata(mem_wrdata_b), .mem_wren(mem_wren_b)
    );

    // ---------------- engine models ----------------
    logic [9:0] cnt_a [3];
    logic [9:0] cnt_b [3];
    logic [2:0] start_a, start_b;
    assign start_a = {prga_en, ksa_en, init_en};
    assign start_b = {prga_en_b, ksa_en_b, init_en_b};

    function automatic logic [9:0] busy_of(input int i);
        case (i)
            0:       return 10'd256;
            1:       return 10'd512;
            default: return 10'd20;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                cnt_a[i] <= '0;
                cnt_b[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (start_a[i]) cnt_a[i] <= busy_of(i);
                else if (cnt_a[i] != 0) cnt_a[i] <= cnt_a[i] - 10'd1;
                if (start_b[i]) cnt_b[i] <= busy_of(i);
                else if (cnt_b[i] != 0) cnt_b[i] <= cnt_b[i] - 10'd1;
            end
        end
    end

    assign init_rdy   = (cnt_a[0] == 0);
    assign ksa_rdy    = (cnt_a[1] == 0) && !hold_ksa;
    assign prga_rdy   = (cnt_a[2] == 0);
    assign init_rdy_b = (cnt_b[0] == 0);
    assign ksa_rdy_b  = (cnt_b[1] == 0);
    assign prga_rdy_b = (cnt_b[2] == 0);

    // ---------------- bounded waits (caller checks ok) ----------------
    task automatic wait_phase(input logic [1:0] p, output bit ok);
        for (int c = 0; c < 2000 && phase !== p; c++) @(negedge clk);
        ok = (phase === p);
    endtask

    task automatic wait_idle(output bit ok);
        for (int c = 0; c < 3000 && rdy !== 1'b1; c++) @(negedge clk);
        ok = (rdy === 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", rdy); end
        n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", phase); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if ({init_en, ksa_en, prga_en} !== 3'b000) begin n_fail++; $display("FAIL reset_en: got %b want 000", {init_en, ksa_en, prga_en}); end
        n_checks++; if ({mem_wren, mem_addr, mem_wrdata} !== 17'd0) begin n_fail++; $display("FAIL reset_mem: got wren=%b addr=%h data=%h want 0/00/00", mem_wren, mem_addr, mem_wrdata); end
        n_checks++; if (rdy_b !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_b: got %b want 1", rdy_b); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (rdy !== 1'b1 || phase !== 2'd0) begin n_fail++; $display("FAIL idle_hold: got rdy=%b phase=%0d want 1/0", rdy, phase); end
        $display("test_reset done");
    endtask

    task automatic test_full_run;
        int rdy_low = 0, n_i = 0, n_k = 0, n_p = 0, bad = 0, n_seq = 0;
        logic [1:0] last = 2'd0;
        logic [7:0] seq_w = 8'd0;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int c = 0; c < 3000 && rdy !== 1'b1; c++) begin
            rdy_low++;
            if (init_en) begin n_i++; if (phase !== 2'd1) bad++; end
            if (ksa_en)  begin n_k++; if (phase !== 2'd2) bad++; end
            if (prga_en) begin n_p++; if (phase !== 2'd3) bad++; end
            if (phase !== last) begin seq_w = {seq_w[5:0], phase}; n_seq++; last = phase; end
            @(negedge clk);
        end
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL run_done: rdy=%b want 1 within bound", rdy); end
        n_checks++; if (rdy_low != 795) begin n_fail++; $display("FAIL run_len: got %0d busy cycles want 795", rdy_low); end
        n_checks++; if (n_i != 1 || n_k != 1 || n_p != 1) begin n_fail++; $display("FAIL run_pulses: got init=%0d ksa=%0d prga=%0d want 1/1/1", n_i, n_k, n_p); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL run_pulse_phase: %0d pulses outside own phase want 0", bad); end
        n_checks++; if (n_seq != 4 || seq_w !== 8'h6C) begin n_fail++; $display("FAIL run_phase_seq: got n=%0d seq=%h want 4/6c", n_seq, seq_w); end
        $display("test_full_run: busy=%0d seq=%h", rdy_low, seq_w);
    endtask

    task automatic test_mux;
        bit ok;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_phase(2'd2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mux_reach_ksa: phase=%0d want 2", phase); end
        ksa_addr = 8'h5A; ksa_wrdata = 8'hC3; ksa_wren = 1'b1;
        #1;
        n_checks++; if ({mem_wren, mem_addr, mem_wrdata} !== {1'b1, 8'h5A, 8'hC3}) begin n_fail++; $display("FAIL mux_ksa: got wren=%b addr=%h data=%h want 1/5a/c3", mem_wren, mem_addr, mem_wrdata); end
        @(negedge clk);
        ksa_wren = 1'b0;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mux_legal_err: got %b want 0", err); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mux_done: rdy=%b want 1", rdy); end
        #1;
        n_checks++; if ({phase, mem_wren, mem_addr, mem_wrdata} !== 19'd0) begin n_fail++; $display("FAIL mux_idle: got phase=%0d wren=%b addr=%h data=%h want 0", phase, mem_wren, mem_addr, mem_wrdata); end
        @(negedge clk);
        $display("test_mux done");
    endtask

    task automatic test_illegal;
        bit ok;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n_checks++; if (phase !== 2'd1) begin n_fail++; $display("FAIL ill_phase: got %0d want 1", phase); end
        prga_wren = 1'b1; init_wren = 1'b0;
        #1;
        n_checks++; if (mem_wren !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL ill_block: got wren=%b err=%b want 0/0", mem_wren, err); end
        init_wren = 1'b1;
        #1;
        n_checks++; if ({mem_wren, mem_addr, mem_wrdata} !== {1'b1, 8'h11, 8'h21}) begin n_fail++; $display("FAIL ill_owner: got wren=%b addr=%h data=%h want 1/11/21", mem_wren, mem_addr, mem_wrdata); end
        @(posedge clk);
        #1;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err_set: got %b want 1", err); end
        prga_wren = 1'b0; init_wren = 1'b0;
        wait_idle(ok);
        n_checks++; if (!ok || err !== 1'b1) begin n_fail++; $display("FAIL ill_err_sticky: got rdy=%b err=%b want 1/1", rdy, err); end
        @(negedge clk);
        $display("test_illegal done");
    endtask

    task automatic test_slow_ready;
        bit ok;
        int n_early = 0;
        hold_ksa = 1'b1;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_phase(2'd2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL slow_reach_ksa: phase=%0d want 2", phase); end
        repeat (10) begin
            if (ksa_en !== 1'b0) n_early++;
            @(negedge clk);
        end
        n_checks++; if (n_early != 0 || phase !== 2'd2) begin n_fail++; $display("FAIL slow_hold: got early=%0d phase=%0d want 0/2", n_early, phase); end
        hold_ksa = 1'b0;
        #1;
        n_checks++; if (ksa_en !== 1'b1) begin n_fail++; $display("FAIL slow_start: got ksa_en=%b want 1", ksa_en); end
        @(negedge clk);
        n_checks++; if (ksa_en !== 1'b0) begin n_fail++; $display("FAIL slow_pulse_width: got ksa_en=%b want 0", ksa_en); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL slow_done: rdy=%b want 1", rdy); end
        @(negedge clk);
        $display("test_slow_ready done");
    endtask

    task automatic test_reset_midksa;
        bit ok;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_phase(2'd2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_reach_ksa: phase=%0d want 2", phase); end
        repeat (20) @(negedge clk);
        ksa_wren = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({rdy, phase, mem_wren, err} !== 5'b1_00_0_0) begin n_fail++; $display("FAIL mid_async: got rdy=%b phase=%0d wren=%b err=%b want 1/0/0/0", rdy, phase, mem_wren, err); end
        ksa_wren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n_checks++; if (phase !== 2'd1 || init_en !== 1'b1) begin n_fail++; $display("FAIL mid_restart: got phase=%0d init_en=%b want 1/1", phase, init_en); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_done: rdy=%b want 1", rdy); end
        @(negedge clk);
        $display("test_reset_midksa done");
    endtask

    task automatic test_back_to_back;
        bit ok;
        en = 1'b1;
        @(negedge clk);
        wait_idle(ok);
        n_checks++; if (!ok || phase !== 2'd0) begin n_fail++; $display("FAIL b2b_idle: got rdy=%b phase=%0d want 1/0", rdy, phase); end
        @(negedge clk);
        en = 1'b0;
        n_checks++; if ({rdy, phase, init_en} !== 4'b0_01_1) begin n_fail++; $display("FAIL b2b_restart: got rdy=%b phase=%0d init_en=%b want 0/1/1", rdy, phase, init_en); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_done: rdy=%b want 1", rdy); end
        @(negedge clk);
        $display("test_back_to_back done");
    endtask

    task automatic test_no_prga;
        int rdy_low = 0, n_p = 0, n_seq = 0;
        logic [1:0] last = 2'd0;
        logic [7:0] seq_w = 8'd0;
        en_b = 1'b1;
        @(negedge clk);
        en_b = 1'b0;
        for (int c = 0; c < 3000 && rdy_b !== 1'b1; c++) begin
            rdy_low++;
            if (prga_en_b) n_p++;
            if (phase_b !== last) begin seq_w = {seq_w[5:0], phase_b}; n_seq++; last = phase_b; end
            @(negedge clk);
        end
        n_checks++; if (rdy_b !== 1'b1 || rdy_low != 773) begin n_fail++; $display("FAIL noprga_len: got rdy=%b busy=%0d want 1/773", rdy_b, rdy_low); end
        n_checks++; if (n_p != 0) begin n_fail++; $display("FAIL noprga_pulse: got %0d prga_en pulses want 0", n_p); end
        n_checks++; if (n_seq != 3 || seq_w !== 8'h18) begin n_fail++; $display("FAIL noprga_seq: got n=%0d seq=%h want 3/18", n_seq, seq_w); end
        n_checks++; if ({err_b, mem_wren_b, mem_addr_b, mem_wrdata_b} !== 18'd0) begin n_fail++; $display("FAIL noprga_idle_mem: got err=%b wren=%b addr=%h data=%h want 0", err_b, mem_wren_b, mem_addr_b, mem_wrdata_b); end
        $display("test_no_prga: busy=%0d seq=%h", rdy_low, seq_w);
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_mux();
        test_illegal();
        test_slow_ready();
        test_reset_midksa();
        test_back_to_back();
        test_no_prga();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arc4_ctrl.md
Name: arc4_ctrl

Overview:
Top-level sequencer for the ARC4 datapath. It runs the init, ksa and prga engines in that order using the ready/enable protocol. It also owns the single-port S memory (256x8), steering its write/address port to whichever engine holds the current phase. It sits between the task top (CLOCK_50/KEY[3] wrapper) and the three engines.

Parameters:
ADDR_W, 8, S-memory address width
DATA_W, 8, S-memory data width
RUN_PRGA, 1, 1 = run prga after ksa; 0 = finish after ksa

Ports:
clk  input  1  system clock (CLOCK_50 at top)
rst_n  input  1  asynchronous active-low reset (KEY[3] at top)
en  input  1  start request; sampled only when rdy=1
rdy  output  1  controller idle, can accept en
phase  output  2  0=none, 1=init, 2=ksa, 3=prga
err  output  1  sticky: non-owner engine asserted wren
init_en / ksa_en / prga_en  output  1 each  one-cycle start pulse to each engine
init_rdy / ksa_rdy / prga_rdy  input  1 each  engine ready
init_addr / ksa_addr / prga_addr  input  ADDR_W each  engine memory address
init_wrdata / ksa_wrdata / prga_wrdata  input  DATA_W each  engine write data
init_wren / ksa_wren / prga_wren  input  1 each  engine write enable
mem_addr  output  ADDR_W  S-memory address
mem_wrdata  output  DATA_W  S-memory write data
mem_wren  output  1  S-memory write enable

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rdy=1; phase=0; err=0.
  - All *_en=0; mem_wren=0; mem_addr=0; mem_wrdata=0.
- States: IDLE, START_INIT, WAIT_INIT, START_KSA, WAIT_KSA, START_PRGA, WAIT_PRGA, DONE.
- IDLE:
  - rdy=1.
  - en=1 -> START_INIT next cycle; rdy=0 from that cycle on.
  - en=0 -> stay in IDLE.
- START_x:
  - Holds until x_rdy=1.
  - In the cycle x_rdy=1, x_en=1 for exactly that one cycle, then go to WAIT_x.
  - x_en is never high in any other cycle.
- WAIT_x:
  - Engine contract: x_rdy is low by the first WAIT_x cycle.
  - Stay while x_rdy=0.
  - x_rdy=1 -> next phase: WAIT_INIT -> START_KSA; WAIT_KSA -> START_PRGA if RUN_PRGA=1, else DONE; WAIT_PRGA -> DONE.
- DONE:
  - One cycle, then IDLE with rdy=1.
  - Minimum end-to-end overhead is 3 cycles per engine plus 2 cycles (IDLE -> START_INIT, DONE -> IDLE).
- phase is a registered output:
  - 1 in START_INIT/WAIT_INIT, 2 in START_KSA/WAIT_KSA, 3 in START_PRGA/WAIT_PRGA.
  - 0 in IDLE/DONE.
- Memory mux:
  - Combinational from the registered phase; zero-latency pass-through of the owner's addr/wrdata/wren.
  - phase=0: mem_addr=0, mem_wrdata=0, mem_wren=0.
- Read data does not pass through this block; engines read the S-memory q directly.
- err:
  - Set when any non-owner x_wren=1, including during phase 0.
  - Clears only on reset.
  - A non-owner write never reaches mem_wren.
- en while rdy=0: ignored, not queued.
- en held high through DONE: a new run starts from IDLE on the following cycle.
- Reset mid-run: returns to IDLE immediately and asynchronously; mem_wren drops in the same instant.
- An engine whose rdy is already 1 on entry to START_x is started with no wait.

Decomposition:
- Package arc4_pkg:
  - typedef enum state_t (8 states).
  - typedef enum logic [1:0] phase_t {PH_NONE, PH_INIT, PH_KSA, PH_PRGA}.
  - Constants S_DEPTH=256, ADDR_W=8, DATA_W=8.
- One sub-module, s_mem_mux: the combinational phase-indexed port mux plus the non-owner write detect.
- The FSM stays in arc4_ctrl.

Test Plan:
- Reset then run: rst_n low 1 cycle. Engine models have rdy=1, busy 256 (init), 512 (ksa) and 20 (prga) cycles. Pulse en -> init_en, ksa_en, prga_en each high exactly 1 cycle, in order; phase steps 1,2,3,0; rdy returns to 1 after the final cycle.
- Mux: in phase 2, ksa drives addr=0x5A, wrdata=0xC3, wren=1 -> mem_addr=0x5A, mem_wrdata=0xC3, mem_wren=1 in the same cycle. In phase 0 -> mem_addr=0, mem_wren=0.
- Illegal write: in phase 1, prga_wren=1 -> mem_wren follows init_wren only; err=1 from the next edge and stays 1 until rst_n low.
- Slow ready: ksa_rdy held 0 for 10 cycles on entry to START_KSA -> ksa_en is asserted only in the first cycle ksa_rdy=1.
- RUN_PRGA=0: full run -> prga_en never asserted; phase goes 2 -> 0.
- Reset mid-ksa: rst_n low asynchronously -> rdy=1, phase=0, mem_wren=0 without a clock edge. A new en restarts from init.
